collision_response: RTL and testbench

COLLISION_RESPONSE -- requirements
Module: collision_response

---
 rtl/galaga_pkg.sv | 28 ++
 rtl/ship_life_tracker.sv | 57 +++++
 rtl/collision_response.sv | 186 ++++++++++++++++++
 tb/tb_collision_response.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galaga_pkg.sv
// Shared types and defaults for the collision response block:
// FSM state enum, parameter defaults and a saturating 16-bit adder.
package galaga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TALLY = 2'd1,
        ST_APPLY = 2'd2,
        ST_PULSE = 2'd3
    } state_e;

    localparam int DEF_N_NPC         = 10;
    localparam int DEF_N_ROCKET      = 15;
    localparam int DEF_NPC_POINTS    = 50;
    localparam int DEF_START_LIVES   = 3;
    localparam int DEF_INVULN_FRAMES = 120;

    // Score additions clamp at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/ship_life_tracker.sv
// Per-ship lives and post-hit immunity counter.
// Ports: clk_i/rst_ni, clear_i restart, apply_i frame step, hit_i, freeze_i -> lives_o, invuln_o.
module ship_life_tracker
    import galaga_pkg::*;
#(
    parameter int START_LIVES   = DEF_START_LIVES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       apply_i,
    input  logic       hit_i,
    input  logic       freeze_i,
    output logic [1:0] lives_o,
    output logic       invuln_o
);

    localparam int CW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // A hit only counts while vulnerable, alive, and the game is live.
    assign accept = hit_i && (cnt_q == '0) && (lives_q != 2'd0) && !freeze_i;

    always_comb begin
        lives_d = lives_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            lives_d = 2'(START_LIVES);
            cnt_d   = '0;
        end else if (apply_i) begin
            if (accept) begin
                lives_d = lives_q - 2'd1;
                cnt_d   = CW'(INVULN_FRAMES);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lives_q <= 2'(START_LIVES);
            cnt_q   <= '0;
        end else begin
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lives_o  = lives_q;
    assign invuln_o = (cnt_q != '0);

endmodule

// File: rtl/collision_response.sv
// Per-frame game-state update: tallies enemy kills, scores, lives, waves.
// Ports: VGA_CLK/Reset, frame_clk strobe, game_start, latched hit flags in;
// scores, lives, invuln, NPC_alive, wave, pulses and status flags out.
module collision_response
    import galaga_pkg::*;
#(
    parameter int N_NPC         = DEF_N_NPC,
    parameter int N_ROCKET      = DEF_N_ROCKET,
    parameter int NPC_POINTS    = DEF_NPC_POINTS,
    parameter int START_LIVES   = DEF_START_LIVES,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic                VGA_CLK,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic                game_start,
    input  logic                Ship_Collision,
    input  logic                Ship_Collision2,
    input  logic [N_ROCKET-1:0] Rocket_Collision,
    input  logic [N_ROCKET-1:0] Rocket_Collision2,
    input  logic [N_NPC-1:0]    NPC_Collision,
    output logic [15:0]         score,
    output logic [15:0]         score2,
    output logic [1:0]          lives,
    output logic [1:0]          lives2,
    output logic                invuln,
    output logic                invuln2,
    output logic [N_NPC-1:0]    NPC_alive,
    output logic [3:0]          wave,
    output logic [N_ROCKET-1:0] rocket_kill,
    output logic [N_ROCKET-1:0] rocket_kill2,
    output logic                update_done,
    output logic                game_over,
    output logic                overrun
);

    localparam int IW = (N_NPC > 1) ? $clog2(N_NPC) : 1;
    localparam int KW = $clog2(N_NPC + 1);

    state_e              state_q;
    logic                fc_q;
    logic [IW-1:0]       idx_q;
    logic [KW-1:0]       kills_q;
    logic [N_NPC-1:0]    cap_npc_q;
    logic [N_ROCKET-1:0] cap_rk_q, cap_rk2_q;
    logic                cap_s1_q, cap_s2_q;
    logic [15:0]         score_q, score2_q;
    logic [N_NPC-1:0]    alive_q;
    logic [3:0]          wave_q;
    logic [N_ROCKET-1:0] kill_q, kill2_q;
    logic                done_q, go_q, ovr_q;

    logic             frame_edge, start, apply, tally_bit;
    logic [15:0]      points;
    logic [N_NPC-1:0] alive_left;

    assign frame_edge = !fc_q && frame_clk;
    assign start      = (state_q == ST_IDLE) && game_start;
    assign apply      = (state_q == ST_APPLY);
    assign tally_bit  = cap_npc_q[idx_q] & alive_q[idx_q];
    assign points     = 16'(kills_q) * 16'(NPC_POINTS);
    assign alive_left = alive_q & ~cap_npc_q;

    always_ff @(posedge VGA_CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            fc_q      <= 1'b0;
            idx_q     <= '0;
            kills_q   <= '0;
            cap_npc_q <= '0;
            cap_rk_q  <= '0;
            cap_rk2_q <= '0;
            cap_s1_q  <= 1'b0;
            cap_s2_q  <= 1'b0;
            score_q   <= '0;
            score2_q  <= '0;
            alive_q   <= '1;
            wave_q    <= '0;
            kill_q    <= '0;
            kill2_q   <= '0;
            done_q    <= 1'b0;
            go_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            fc_q    <= frame_clk;
            done_q  <= 1'b0;
            kill_q  <= '0;
            kill2_q <= '0;
            go_q    <= (lives == 2'd0) && (lives2 == 2'd0);
            if (frame_edge && state_q != ST_IDLE)
                ovr_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (game_start) begin
                        // Restart beats a coincident frame edge.
                        idx_q    <= '0;
                        kills_q  <= '0;
                        score_q  <= '0;
                        score2_q <= '0;
                        alive_q  <= '1;
                        wave_q   <= '0;
                        go_q     <= 1'b0;
                        ovr_q    <= 1'b0;
                    end else if (frame_edge) begin
                        cap_npc_q <= NPC_Collision;
                        cap_rk_q  <= Rocket_Collision;
                        cap_rk2_q <= Rocket_Collision2;
                        cap_s1_q  <= Ship_Collision;
                        cap_s2_q  <= Ship_Collision2;
                        idx_q     <= '0;
                        kills_q   <= '0;
                        state_q   <= ST_TALLY;
                    end
                end
                ST_TALLY: begin
                    kills_q <= kills_q + KW'(tally_bit);
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == IW'(N_NPC - 1))
                        state_q <= ST_APPLY;
                end
                ST_APPLY: begin
                    if (!go_q) begin
                        if (|cap_rk_q)
                            score_q <= sat_add16(score_q, points);
                        else if (|cap_rk2_q)
                            score2_q <= sat_add16(score2_q, points);
                    end
                    // Wave cleared: respawn the whole formation at once.
                    if (alive_left == '0) begin
                        alive_q <= '1;
                        wave_q  <= wave_q + 4'd1;
                    end else begin
                        alive_q <= alive_left;
                    end
                    state_q <= ST_PULSE;
                end
                ST_PULSE: begin
                    done_q  <= 1'b1;
                    kill_q  <= cap_rk_q;
                    kill2_q <= cap_rk2_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ship_life_tracker #(
        .START_LIVES  (START_LIVES),
        .INVULN_FRAMES(INVULN_FRAMES)
    ) u_ship1 (
        .clk_i   (VGA_CLK),
        .rst_ni  (Reset),
        .clear_i (start),
        .apply_i (apply),
        .hit_i   (cap_s1_q),
        .freeze_i(go_q),
        .lives_o (lives),
        .invuln_o(invuln)
    );

    ship_life_tracker #(
        .START_LIVES  (START_LIVES),
        .INVULN_FRAMES(INVULN_FRAMES)
    ) u_ship2 (
        .clk_i   (VGA_CLK),
        .rst_ni  (Reset),
        .clear_i (start),
        .apply_i (apply),
        .hit_i   (cap_s2_q),
        .freeze_i(go_q),
        .lives_o (lives2),
        .invuln_o(invuln2)
    );

    assign score        = score_q;
    assign score2       = score2_q;
    assign NPC_alive    = alive_q;
    assign wave         = wave_q;
    assign rocket_kill  = kill_q;
    assign rocket_kill2 = kill2_q;
    assign update_done  = done_q;
    assign game_over    = go_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_collision_response.sv
// Testbench for collision_response: scenario tasks checked against
// a frame-level behavioural model of the game rules.
module tb_collision_response;

    localparam int NN  = 10;
    localparam int NR  = 15;
    localparam int PTS = 50;
    localparam int INV = 120;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_clk = 1'b0;
    logic          game_start = 1'b0;
    logic          s1 = 1'b0, s2 = 1'b0;
    logic [NR-1:0] rk = '0, rk2 = '0;
    logic [NN-1:0] npc = '0;

    logic [15:0]   score, score2;
    logic [1:0]    lives, lives2;
    logic          invuln, invuln2;
    logic [NN-1:0] NPC_alive;
    logic [3:0]    wave;
    logic [NR-1:0] rocket_kill, rocket_kill2;
    logic          update_done, game_over, overrun;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    int      m_score, m_score2, m_wave;
    int      m_lives[2];
    int      m_inv[2];
    bit [NN-1:0] m_alive;
    bit      m_go, m_ovr;

    always #5 clk = ~clk;

    collision_response dut (
        .VGA_CLK          (clk),
        .Reset            (rst_n),
        .frame_clk        (frame_clk),
        .game_start       (game_start),
        .Ship_Collision   (s1),
        .Ship_Collision2  (s2),
        .Rocket_Collision (rk),
        .Rocket_Collision2(rk2),
        .NPC_Collision    (npc),
        .score            (score),
        .score2           (score2),
        .lives            (lives),
        .lives2           (lives2),
        .invuln           (invuln),
        .invuln2          (invuln2),
        .NPC_alive        (NPC_alive),
        .wave             (wave),
        .rocket_kill      (rocket_kill),
        .rocket_kill2     (rocket_kill2),
        .update_done      (update_done),
        .game_over        (game_over),
        .overrun          (overrun)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void m_reset();
        m_score  = 0;
        m_score2 = 0;
        m_wave   = 0;
        m_lives[0] = 3;
        m_lives[1] = 3;
        m_inv[0] = 0;
        m_inv[1] = 0;
        m_alive  = '1;
        m_go     = 1'b0;
        m_ovr    = 1'b0;
    endfunction

    function automatic void model_frame(
        input bit [NN-1:0] f_npc,
        input bit [NR-1:0] f_rk,
        input bit [NR-1:0] f_rk2,
        input bit f_s1,
        input bit f_s2
    );
        int k;
        bit hit[2];
        k = $countones(f_npc & m_alive);
        if (!m_go) begin
            if (f_rk != 0) m_score = m_score + k * PTS;
            else if (f_rk2 != 0) m_score2 = m_score2 + k * PTS;
            if (m_score > 65535) m_score = 65535;
            if (m_score2 > 65535) m_score2 = 65535;
        end
        m_alive = m_alive & ~f_npc;
        if (m_alive == 0) begin
            m_alive = '1;
            m_wave = (m_wave + 1) % 16;
        end
        hit[0] = f_s1;
        hit[1] = f_s2;
        for (int i = 0; i < 2; i++) begin
            if (hit[i] && m_inv[i] == 0 && m_lives[i] > 0 && !m_go) begin
                m_lives[i] = m_lives[i] - 1;
                m_inv[i] = INV;
            end else if (m_inv[i] > 0) begin
                m_inv[i] = m_inv[i] - 1;
            end
        end
        m_go = (m_lives[0] == 0) && (m_lives[1] == 0);
    endfunction

    function automatic logic [54:0] st_dut();
        return {score, score2, lives, lives2, invuln, invuln2,
                NPC_alive, wave, game_over, overrun};
    endfunction

    function automatic logic [54:0] st_model();
        return {16'(m_score), 16'(m_score2), 2'(m_lives[0]), 2'(m_lives[1]),
                m_inv[0] != 0, m_inv[1] != 0, m_alive, 4'(m_wave), m_go, m_ovr};
    endfunction

    task automatic run_frame(
        input logic [NN-1:0] f_npc,
        input logic [NR-1:0] f_rk,
        input logic [NR-1:0] f_rk2,
        input logic f_s1,
        input logic f_s2,
        output int lat,
        output logic [NR-1:0] ks,
        output logic [NR-1:0] ks2
    );
        @(negedge clk);
        npc = f_npc; rk = f_rk; rk2 = f_rk2; s1 = f_s1; s2 = f_s2;
        frame_clk = 1'b1;
        @(posedge clk); #1;
        npc = '0; rk = '0; rk2 = '0; s1 = 1'b0; s2 = 1'b0;
        frame_clk = 1'b0;
        lat = -1; ks = '0; ks2 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (update_done) begin
                lat = c; ks = rocket_kill; ks2 = rocket_kill2;
                break;
            end
        end
        model_frame(f_npc, f_rk, f_rk2, f_s1, f_s2);
    endtask

    task automatic do_start();
        @(negedge clk);
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        m_reset();
        n_total++;
        if (st_dut() !== st_model())
            $display("FAIL reset_state got=%h exp=%h", st_dut(), st_model());
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({update_done, rocket_kill, rocket_kill2} !== '0)
            $display("FAIL reset_pulses got=%b/%h/%h exp=0",
                     update_done, rocket_kill, rocket_kill2);
        else n_pass++;
    endtask

    task automatic test_directed();
        int lat;
        logic [NR-1:0] ks, ks2;
        run_frame(10'b0000000101, 15'h0001, '0, 1'b0, 1'b0, lat, ks, ks2);
        n_total++;
        if (lat !== 12) $display("FAIL dir_latency got=%0d exp=12", lat);
        else n_pass++;
        n_total++;
        if (ks !== 15'h0001 || ks2 !== '0)
            $display("FAIL dir_rocket_kill got=%h/%h exp=0001/0000", ks, ks2);
        else n_pass++;
        n_total++;
        if (score !== 16'd100 || NPC_alive !== 10'b1111111010)
            $display("FAIL dir_score_alive got=%0d/%b exp=100/1111111010",
                     score, NPC_alive);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (update_done !== 1'b0 || rocket_kill !== '0)
            $display("FAIL dir_pulse_width got=%b/%h exp=0/0000",
                     update_done, rocket_kill);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        logic [NR-1:0] ks, ks2, r1, r2;
        logic [NN-1:0] n;
        logic a, b;
        do_start();
        for (int f = 0; f < 40; f++) begin
            n  = NN'($urandom) & NN'($urandom);
            r1 = ($urandom_range(0, 2) == 0) ? '0 : NR'(1 << $urandom_range(0, NR - 1));
            r2 = ($urandom_range(0, 1) == 0) ? '0 : NR'($urandom);
            a  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 5) == 0);
            run_frame(n, r1, r2, a, b, lat, ks, ks2);
            n_total++;
            if (lat !== 12) $display("FAIL rnd_latency f=%0d got=%0d exp=12", f, lat);
            else n_pass++;
            n_total++;
            if (ks !== r1 || ks2 !== r2)
                $display("FAIL rnd_kill f=%0d got=%h/%h exp=%h/%h", f, ks, ks2, r1, r2);
            else n_pass++;
            n_total++;
            if (st_dut() !== st_model())
                $display("FAIL rnd_state f=%0d got=%h exp=%h", f, st_dut(), st_model());
            else n_pass++;
        end
    endtask

    task automatic test_lives();
        int lat, inv_frames;
        logic [NR-1:0] ks, ks2;
        do_start();
        inv_frames = 0;
        for (int f = 1; f <= 121; f++) begin
            run_frame('0, '0, '0, f <= 2, 1'b0, lat, ks, ks2);
            if (invuln === 1'b1) inv_frames++;
            if (f == 2) begin
                n_total++;
                if (lives !== 2'd2 || invuln !== 1'b1)
                    $display("FAIL lives_double_hit got=%0d/%b exp=2/1", lives, invuln);
                else n_pass++;
            end
        end
        n_total++;
        if (inv_frames !== INV)
            $display("FAIL invuln_frames got=%0d exp=%0d", inv_frames, INV);
        else n_pass++;
        run_frame('0, '0, '0, 1'b1, 1'b0, lat, ks, ks2);
        n_total++;
        if (lives !== 2'd1 || st_dut() !== st_model())
            $display("FAIL lives_third_hit got=%0d/%h exp=1/%h", lives, st_dut(), st_model());
        else n_pass++;
    endtask

    task automatic test_wave();
        int lat;
        logic [NR-1:0] ks, ks2;
        do_start();
        run_frame(10'h1FF, 15'h0001, '0, 1'b0, 1'b0, lat, ks, ks2);
        run_frame(10'h200, 15'h0001, '0, 1'b0, 1'b0, lat, ks, ks2);
        n_total++;
        if (NPC_alive !== 10'h3FF || wave !== 4'd1)
            $display("FAIL wave_reload got=%h/%0d exp=3ff/1", NPC_alive, wave);
        else n_pass++;
        for (int i = 0; i < 15; i++)
            run_frame(10'h3FF, '0, '0, 1'b0, 1'b0, lat, ks, ks2);
        n_total++;
        if (wave !== 4'd0 || NPC_alive !== 10'h3FF)
            $display("FAIL wave_wrap got=%0d/%h exp=0/3ff", wave, NPC_alive);
        else n_pass++;
        n_total++;
        if (st_dut() !== st_model())
            $display("FAIL wave_state got=%h exp=%h", st_dut(), st_model());
        else n_pass++;
    endtask

    task automatic test_saturate();
        int lat;
        logic [NR-1:0] ks, ks2;
        do_start();
        for (int i = 0; i < 131; i++)
            run_frame(10'h3FF, 15'h0004, '0, 1'b0, 1'b0, lat, ks, ks2);
        n_total++;
        if (score !== 16'd65500)
            $display("FAIL sat_pre got=%0d exp=65500", score);
        else n_pass++;
        run_frame(10'h001, 15'h0004, '0, 1'b0, 1'b0, lat, ks, ks2);
        n_total++;
        if (score !== 16'hFFFF || st_dut() !== st_model())
            $display("FAIL sat_clamp got=%h exp=ffff", score);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int seen;
        do_start();
        @(negedge clk);
        npc = 10'h001; rk = 15'h0001; frame_clk = 1'b1;
        @(posedge clk); #1;
        npc = '0; rk = '0; frame_clk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        npc = 10'h002; rk = 15'h0001; frame_clk = 1'b1;
        @(posedge clk); #1;
        npc = '0; rk = '0; frame_clk = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (update_done) begin seen = 1; break; end
        end
        model_frame(10'h001, 15'h0001, '0, 1'b0, 1'b0);
        m_ovr = 1'b1;
        n_total++;
        if (seen !== 1) $display("FAIL ovr_done got=%0d exp=1", seen);
        else n_pass++;
        n_total++;
        if (overrun !== 1'b1 || st_dut() !== st_model())
            $display("FAIL ovr_state got=%h exp=%h", st_dut(), st_model());
        else n_pass++;
        repeat (3) @(posedge clk);
        do_start();
        #1;
        n_total++;
        if (overrun !== 1'b0 || lives !== 2'd3 || st_dut() !== st_model())
            $display("FAIL ovr_clear got=%h exp=%h", st_dut(), st_model());
        else n_pass++;
    endtask

    task automatic test_start_vs_frame();
        int lat, seen;
        logic [NR-1:0] ks, ks2;
        run_frame(10'h00F, 15'h0002, '0, 1'b1, 1'b0, lat, ks, ks2);
        @(negedge clk);
        game_start = 1'b1; frame_clk = 1'b1;
        npc = 10'h3FF; rk = 15'h0001;
        @(posedge clk); #1;
        game_start = 1'b0; frame_clk = 1'b0;
        npc = '0; rk = '0;
        m_reset();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (update_done) seen = 1;
        end
        n_total++;
        if (seen !== 0) $display("FAIL start_win_done got=%0d exp=0", seen);
        else n_pass++;
        n_total++;
        if (st_dut() !== st_model())
            $display("FAIL start_win_state got=%h exp=%h", st_dut(), st_model());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, seen;
        logic [NR-1:0] ks, ks2;
        run_frame(10'h003, 15'h0001, '0, 1'b0, 1'b0, lat, ks, ks2);
        @(negedge clk);
        npc = 10'h3FF; rk = 15'h0001; s1 = 1'b1; frame_clk = 1'b1;
        @(posedge clk); #1;
        npc = '0; rk = '0; s1 = 1'b0; frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        n_total++;
        if (st_dut() !== st_model() || update_done !== 1'b0)
            $display("FAIL rst_mid_state got=%h exp=%h", st_dut(), st_model());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (update_done) seen = 1;
        end
        n_total++;
        if (seen !== 0 || st_dut() !== st_model())
            $display("FAIL rst_mid_after got=%0d/%h exp=0/%h", seen, st_dut(), st_model());
        else n_pass++;
    endtask

    task automatic test_game_over();
        int lat;
        logic [NR-1:0] ks, ks2;
        do_start();
        for (int f = 0; f < 243; f++)
            run_frame('0, '0, '0, 1'b1, 1'b1, lat, ks, ks2);
        n_total++;
        if (game_over !== 1'b1 || lives !== 2'd0 || lives2 !== 2'd0)
            $display("FAIL go_flag got=%b/%0d/%0d exp=1/0/0", game_over, lives, lives2);
        else n_pass++;
        run_frame(10'h001, 15'h0001, '0, 1'b1, 1'b1, lat, ks, ks2);
        run_frame(10'h002, '0, 15'h0010, 1'b0, 1'b0, lat, ks, ks2);
        n_total++;
        if (score !== 16'd0 || score2 !== 16'd0 || st_dut() !== st_model())
            $display("FAIL go_frozen got=%h exp=%h", st_dut(), st_model());
        else n_pass++;
        n_total++;
        if (lat !== 12) $display("FAIL go_frames_run got=%0d exp=12", lat);
        else n_pass++;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_directed();
        test_random();
        test_lives();
        test_wave();
        test_saturate();
        test_overrun();
        test_start_vs_frame();
        test_reset_mid();
        test_game_over();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
